// File: rtl/multicycle_control.sv
// multicycle_control: Moore controller for a multicycle MIPS-style datapath.
// Optional JUMP state enabled by defining MULTICYCLE_CONTROL_JUMP_EN; without
// it, opcode 0x02 decodes as illegal.
module multicycle_control #(
  parameter int unsigned ALU_OP_WIDTH = 3
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic [5:0]              opcode_i,
  input  logic                    mem_ready_i,
  output logic                    pc_write_o,
  output logic                    pc_write_cond_eq_o,
  output logic                    pc_write_cond_ne_o,
  output logic                    i_or_d_o,
  output logic                    mem_read_o,
  output logic                    mem_write_o,
  output logic                    ir_write_o,
  output logic                    reg_dst_o,
  output logic                    mem_to_reg_o,
  output logic                    reg_write_o,
  output logic                    alu_src_a_o,
  output logic [1:0]              alu_src_b_o,
  output logic [ALU_OP_WIDTH-1:0] alu_op_o,
  output logic [1:0]              pc_source_o,
  output logic                    illegal_op_o,
  output logic [3:0]              state_o
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_I_EXEC   = 4'd9,
    S_I_WB     = 4'd10
`ifdef MULTICYCLE_CONTROL_JUMP_EN
    , S_JUMP   = 4'd11
`endif
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD   = ALU_OP_WIDTH'(0);
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB   = ALU_OP_WIDTH'(1);
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OR    = ALU_OP_WIDTH'(2);
  localparam logic [ALU_OP_WIDTH-1:0] ALU_FUNCT = ALU_OP_WIDTH'(7);

  state_e                  state_q, state_d;
  logic [5:0]              op_q, op_d;
  logic                    illegal_d;
  logic                    fetch_q, fetch_d;
  logic                    jump_q, jump_d;
  logic                    cond_eq_q, cond_eq_d;
  logic                    cond_ne_q, cond_ne_d;
  logic                    i_or_d_q, i_or_d_d;
  logic                    mem_read_q, mem_read_d;
  logic                    mem_write_q, mem_write_d;
  logic                    reg_dst_q, reg_dst_d;
  logic                    mem_to_reg_q, mem_to_reg_d;
  logic                    reg_write_q, reg_write_d;
  logic                    alu_src_a_q, alu_src_a_d;
  logic [1:0]              alu_src_b_q, alu_src_b_d;
  logic [ALU_OP_WIDTH-1:0] alu_op_q, alu_op_d;
  logic [1:0]              pc_source_q, pc_source_d;

  // Next state, captured opcode and illegal-opcode detection.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    illegal_d = 1'b0;
    unique case (state_q)
      S_FETCH:    if (mem_ready_i) state_d = S_DECODE;
      S_DECODE: begin
        op_d = opcode_i;
        case (opcode_i)
          OP_RTYPE:      state_d = S_R_EXEC;
          OP_LW, OP_SW:  state_d = S_MEM_ADDR;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_ADDI, OP_ORI: state_d = S_I_EXEC;
`ifdef MULTICYCLE_CONTROL_JUMP_EN
          OP_J:          state_d = S_JUMP;
`endif
          default: begin
            state_d   = S_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR: state_d = (op_q == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   if (mem_ready_i) state_d = S_MEM_WB;
      S_MEM_WR:   if (mem_ready_i) state_d = S_FETCH;
      S_R_EXEC:   state_d = S_R_WB;
      S_I_EXEC:   state_d = S_I_WB;
      default:    state_d = S_FETCH;
    endcase
  end

  // Moore outputs decoded from the upcoming state so they leave a register;
  // op_d carries the opcode being captured on the DECODE exit edge.
  always_comb begin
    fetch_d      = 1'b0;
    jump_d       = 1'b0;
    cond_eq_d    = 1'b0;
    cond_ne_d    = 1'b0;
    i_or_d_d     = 1'b0;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    reg_dst_d    = 1'b0;
    mem_to_reg_d = 1'b0;
    reg_write_d  = 1'b0;
    alu_src_a_d  = 1'b0;
    alu_src_b_d  = '0;
    alu_op_d     = ALU_ADD;
    pc_source_d  = '0;
    unique case (state_d)
      S_FETCH: begin
        fetch_d     = 1'b1;
        mem_read_d  = 1'b1;
        alu_src_b_d = 2'd1;
      end
      S_DECODE:   alu_src_b_d = 2'd3;
      S_MEM_ADDR: begin
        alu_src_a_d = 1'b1;
        alu_src_b_d = 2'd2;
      end
      S_MEM_RD: begin
        mem_read_d = 1'b1;
        i_or_d_d   = 1'b1;
      end
      S_MEM_WB: begin
        reg_write_d  = 1'b1;
        mem_to_reg_d = 1'b1;
      end
      S_MEM_WR: begin
        mem_write_d = 1'b1;
        i_or_d_d    = 1'b1;
      end
      S_R_EXEC: begin
        alu_src_a_d = 1'b1;
        alu_op_d    = ALU_FUNCT;
      end
      S_R_WB: begin
        reg_write_d = 1'b1;
        reg_dst_d   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a_d = 1'b1;
        alu_op_d    = ALU_SUB;
        pc_source_d = 2'd1;
        cond_eq_d   = (op_d == OP_BEQ);
        cond_ne_d   = (op_d == OP_BNE);
      end
      S_I_EXEC: begin
        alu_src_a_d = 1'b1;
        alu_src_b_d = 2'd2;
        alu_op_d    = (op_d == OP_ORI) ? ALU_OR : ALU_ADD;
      end
      S_I_WB:     reg_write_d = 1'b1;
`ifdef MULTICYCLE_CONTROL_JUMP_EN
      S_JUMP: begin
        jump_d      = 1'b1;
        pc_source_d = 2'd2;
      end
`endif
      default: ;
    endcase
  end

  // State, held opcode and registered outputs; reset lands on FETCH values.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= S_FETCH;
      op_q         <= '0;
      fetch_q      <= 1'b1;
      jump_q       <= 1'b0;
      cond_eq_q    <= 1'b0;
      cond_ne_q    <= 1'b0;
      i_or_d_q     <= 1'b0;
      mem_read_q   <= 1'b1;
      mem_write_q  <= 1'b0;
      reg_dst_q    <= 1'b0;
      mem_to_reg_q <= 1'b0;
      reg_write_q  <= 1'b0;
      alu_src_a_q  <= 1'b0;
      alu_src_b_q  <= 2'd1;
      alu_op_q     <= ALU_ADD;
      pc_source_q  <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      fetch_q      <= fetch_d;
      jump_q       <= jump_d;
      cond_eq_q    <= cond_eq_d;
      cond_ne_q    <= cond_ne_d;
      i_or_d_q     <= i_or_d_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      reg_dst_q    <= reg_dst_d;
      mem_to_reg_q <= mem_to_reg_d;
      reg_write_q  <= reg_write_d;
      alu_src_a_q  <= alu_src_a_d;
      alu_src_b_q  <= alu_src_b_d;
      alu_op_q     <= alu_op_d;
      pc_source_q  <= pc_source_d;
    end
  end

  // IR/PC strobes in FETCH qualify on the live handshake and are held off in reset.
  assign ir_write_o         = fetch_q & mem_ready_i & reset_n_i;
  assign pc_write_o         = jump_q | ir_write_o;
  assign illegal_op_o       = illegal_d;
  assign pc_write_cond_eq_o = cond_eq_q;
  assign pc_write_cond_ne_o = cond_ne_q;
  assign i_or_d_o           = i_or_d_q;
  assign mem_read_o         = mem_read_q;
  assign mem_write_o        = mem_write_q;
  assign reg_dst_o          = reg_dst_q;
  assign mem_to_reg_o       = mem_to_reg_q;
  assign reg_write_o        = reg_write_q;
  assign alu_src_a_o        = alu_src_a_q;
  assign alu_src_b_o        = alu_src_b_q;
  assign alu_op_o           = alu_op_q;
  assign pc_source_o        = pc_source_q;
  assign state_o            = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: instruction-level reference model that expands each
// instruction into its expected per-cycle state trace, replayed against the DUT.
module tb_multicycle_control;

  logic       clk_i = 1'b0;
  logic       reset_n_i = 1'b0;
  logic [5:0] opcode_i = '0;
  logic       mem_ready_i = 1'b0;
  logic       pc_write_o, pc_write_cond_eq_o, pc_write_cond_ne_o;
  logic       i_or_d_o, mem_read_o, mem_write_o, ir_write_o;
  logic       reg_dst_o, mem_to_reg_o, reg_write_o, alu_src_a_o;
  logic [1:0] alu_src_b_o, pc_source_o;
  logic [2:0] alu_op_o;
  logic       illegal_op_o;
  logic [3:0] state_o;

  multicycle_control #(.ALU_OP_WIDTH(3)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .opcode_i(opcode_i), .mem_ready_i(mem_ready_i),
    .pc_write_o(pc_write_o), .pc_write_cond_eq_o(pc_write_cond_eq_o),
    .pc_write_cond_ne_o(pc_write_cond_ne_o), .i_or_d_o(i_or_d_o), .mem_read_o(mem_read_o),
    .mem_write_o(mem_write_o), .ir_write_o(ir_write_o), .reg_dst_o(reg_dst_o),
    .mem_to_reg_o(mem_to_reg_o), .reg_write_o(reg_write_o), .alu_src_a_o(alu_src_a_o),
    .alu_src_b_o(alu_src_b_o), .alu_op_o(alu_op_o), .pc_source_o(pc_source_o),
    .illegal_op_o(illegal_op_o), .state_o(state_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int unsigned st;
    bit          rdy;
  } cyc_t;

  cyc_t        plan[$];
  int unsigned n_total = 0;
  int unsigned n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d want=%0d @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit legal(input int unsigned op);
    case (op)
      'h00, 'h23, 'h2B, 'h04, 'h05, 'h08, 'h0D: return 1'b1;
`ifdef MULTICYCLE_CONTROL_JUMP_EN
      'h02: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  // Expected cycle sequence of one instruction: fw FETCH stalls, mw memory stalls.
  task automatic build(input int unsigned op, input int unsigned fw, input int unsigned mw);
    for (int unsigned i = 0; i < fw; i++) plan.push_back('{0, 1'b0});
    plan.push_back('{0, 1'b1});
    plan.push_back('{1, 1'($urandom_range(1))});
    if (!legal(op)) return;
    case (op)
      'h00: begin plan.push_back('{6, 1'b1}); plan.push_back('{7, 1'b1}); end
      'h08, 'h0D: begin plan.push_back('{9, 1'b1}); plan.push_back('{10, 1'b1}); end
      'h04, 'h05: plan.push_back('{8, 1'($urandom_range(1))});
      'h02: plan.push_back('{11, 1'($urandom_range(1))});
      'h23, 'h2B: begin
        plan.push_back('{2, 1'($urandom_range(1))});
        for (int unsigned i = 0; i < mw; i++) plan.push_back('{(op == 'h23) ? 3 : 5, 1'b0});
        plan.push_back('{(op == 'h23) ? 3 : 5, 1'b1});
        if (op == 'h23) plan.push_back('{4, 1'($urandom_range(1))});
      end
      default: ;
    endcase
  endtask

  // Output table per state for the instruction op, given this cycle's handshake.
  task automatic check_cycle(input int unsigned st, input int unsigned op, input bit rdy);
    int unsigned e_mr = 0, e_iod = 0, e_mw = 0, e_ir = 0, e_pw = 0, e_eq = 0, e_ne = 0;
    int unsigned e_rd = 0, e_m2r = 0, e_rw = 0, e_sa = 0, e_sb = 0, e_aop = 0, e_ps = 0, e_ill = 0;
    case (st)
      0:  begin e_mr = 1; e_sb = 1; e_ir = rdy; e_pw = rdy; end
      1:  begin e_sb = 3; e_ill = !legal(op); end
      2:  begin e_sa = 1; e_sb = 2; end
      3:  begin e_mr = 1; e_iod = 1; end
      4:  begin e_rw = 1; e_m2r = 1; end
      5:  begin e_mw = 1; e_iod = 1; end
      6:  begin e_sa = 1; e_aop = 7; end
      7:  begin e_rw = 1; e_rd = 1; end
      8:  begin e_sa = 1; e_aop = 1; e_ps = 1; e_eq = (op == 'h04); e_ne = (op == 'h05); end
      9:  begin e_sa = 1; e_sb = 2; e_aop = (op == 'h0D) ? 2 : 0; end
      10: e_rw = 1;
      11: begin e_pw = 1; e_ps = 2; end
      default: ;
    endcase
    chk("state", state_o, st);
    chk("mem_read", mem_read_o, e_mr);
    chk("i_or_d", i_or_d_o, e_iod);
    chk("mem_write", mem_write_o, e_mw);
    chk("ir_write", ir_write_o, e_ir);
    chk("pc_write", pc_write_o, e_pw);
    chk("cond_eq", pc_write_cond_eq_o, e_eq);
    chk("cond_ne", pc_write_cond_ne_o, e_ne);
    chk("reg_dst", reg_dst_o, e_rd);
    chk("mem_to_reg", mem_to_reg_o, e_m2r);
    chk("reg_write", reg_write_o, e_rw);
    chk("alu_src_a", alu_src_a_o, e_sa);
    chk("alu_src_b", alu_src_b_o, e_sb);
    chk("alu_op", alu_op_o, e_aop);
    chk("pc_source", pc_source_o, e_ps);
    chk("illegal", illegal_op_o, e_ill);
  endtask

  // Drive each planned cycle at the falling edge; opcode_i is noise outside DECODE.
  task automatic replay(input int unsigned op);
    while (plan.size() > 0) begin
      cyc_t c;
      c = plan.pop_front();
      @(negedge clk_i);
      mem_ready_i = c.rdy;
      opcode_i    = (c.st == 1) ? 6'(op) : 6'($urandom_range(63));
      #1;
      check_cycle(c.st, op, c.rdy);
    end
  endtask

  task automatic run(input int unsigned op, input int unsigned fw, input int unsigned mw);
    build(op, fw, mw);
    replay(op);
  endtask

  initial begin
    int unsigned ops[9];
    ops = '{'h00, 'h23, 'h2B, 'h04, 'h05, 'h08, 'h0D, 'h02, 'h3F};

    // In reset with a ready memory: FETCH values but no IR/PC strobes.
    mem_ready_i = 1'b1;
    #12;
    chk("rst_state", state_o, 0);
    chk("rst_ir_write", ir_write_o, 0);
    chk("rst_pc_write", pc_write_o, 0);
    chk("rst_mem_read", mem_read_o, 1);
    chk("rst_alu_src_b", alu_src_b_o, 1);
    chk("rst_illegal", illegal_op_o, 0);
    @(negedge clk_i);
    mem_ready_i = 1'b0;
    reset_n_i   = 1'b1;

    run('h08, 0, 0);   // ADDI: 0,1,9,10
    run('h23, 1, 2);   // LW with two MEM_RD stalls
    run('h05, 0, 0);   // BNE
    run('h04, 2, 0);   // BEQ
    run('h3F, 0, 0);   // illegal
    run('h02, 0, 0);   // J or illegal depending on build
    run('h0D, 0, 0);   // ORI
    run('h00, 0, 0);   // R-type
    run('h2B, 0, 3);   // SW with stalls

    // Reset asserted while SW waits in MEM_WR must take effect without a clock edge.
    plan.push_back('{0, 1'b1});
    plan.push_back('{1, 1'b1});
    plan.push_back('{2, 1'b1});
    plan.push_back('{5, 1'b0});
    replay('h2B);
    @(negedge clk_i);
    mem_ready_i = 1'b0;
    #1;
    chk("wait_state", state_o, 5);
    reset_n_i = 1'b0;
    #1;
    chk("async_state", state_o, 0);
    chk("async_mem_write", mem_write_o, 0);
    chk("async_mem_read", mem_read_o, 1);
    repeat (2) @(negedge clk_i);
    reset_n_i = 1'b1;

    for (int unsigned n = 0; n < 80; n++) begin
      int unsigned op;
      op = ops[$urandom_range(8)];
      if ($urandom_range(7) == 0) op = $urandom_range(63);
      run(op, $urandom_range(2), $urandom_range(2));
    end
    plan.push_back('{0, 1'b0});
    replay(0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
